// File: rtl/relu_pool_stream.sv
`default_nettype none
// ============================================================================
// Module   : relu_pool_stream
// Purpose  : Streaming 2x2 / stride-2 max-pool stage with optional fused ReLU.
//            Accepts one pixel per beat (D signed channels packed) in raster
//            order and emits one pooled pixel per 2x2 window. o_last marks
//            the final pooled pixel of each frame.
// Ports    : clk      - clock, rising edge
//            resetn   - asynchronous active-low reset
//            i_valid  - input beat valid
//            o_ready  - block can accept an input beat
//            i_data   - input pixel, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//            o_valid  - pooled output beat valid
//            i_ready  - downstream accepts output beat
//            o_data   - pooled pixel, same packing as i_data
//            o_last   - final pooled pixel of the frame
// Config   : define RELU_FUSE_EN to clamp negative outputs to zero.
// Revision : 1.0 - initial release
// ============================================================================
module relu_pool_stream #(
  parameter int H          = 24,
  parameter int W          = 24,
  parameter int D          = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [D*DATA_WIDTH-1:0]    i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [D*DATA_WIDTH-1:0]    o_data,
  output logic                       o_last
);

  localparam int c_PIX_W    = D * DATA_WIDTH;
  localparam int c_COL_W    = (W > 1) ? $clog2(W) : 1;
  localparam int c_ROW_W    = (H > 1) ? $clog2(H) : 1;
  // Line buffer is rounded up to a power of two so the index never needs
  // a width adjustment; the extra entries are simply never addressed.
  localparam int c_LB_AW    = (W / 2 > 1) ? $clog2(W / 2) : 1;
  localparam int c_LB_DEPTH = 1 << c_LB_AW;

  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;
  logic [c_PIX_W-1:0] r_h;
  logic [c_PIX_W-1:0] r_lb [c_LB_DEPTH];
  logic               r_valid;
  logic [c_PIX_W-1:0] r_data;
  logic               r_last;

  logic               w_accept;
  logic               w_col_last;
  logic               w_row_last;
  logic               w_col_odd;
  logic               w_row_odd;
  logic               w_load;
  logic [c_LB_AW-1:0] w_lb_idx;
  logic [c_PIX_W-1:0] w_lb_rd;
  logic [c_PIX_W-1:0] w_hmax;
  logic [c_PIX_W-1:0] w_res;

  // Ready depends only on the output register: it can take a beat whenever
  // the register is empty or is being drained this cycle.
  assign o_ready    = !r_valid || i_ready;
  assign w_accept   = i_valid && o_ready;
  assign w_col_last = (r_col == c_COL_W'(W - 1));
  assign w_row_last = (r_row == c_ROW_W'(H - 1));
  assign w_col_odd  = r_col[0];
  assign w_row_odd  = r_row[0];
  assign w_load     = w_accept && w_col_odd && w_row_odd;
  assign w_lb_idx   = c_LB_AW'(r_col >> 1);
  assign w_lb_rd    = r_lb[w_lb_idx];

  // Per-channel signed compare tree: horizontal max of the held even-column
  // pixel and the current pixel, then vertical max against the line buffer.
  for (genvar k = 0; k < D; k++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] w_px;
    logic signed [DATA_WIDTH-1:0] w_hd;
    logic signed [DATA_WIDTH-1:0] w_lbv;
    logic signed [DATA_WIDTH-1:0] w_hm;
    logic signed [DATA_WIDTH-1:0] w_mx;

    assign w_px  = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign w_hd  = r_h[k*DATA_WIDTH +: DATA_WIDTH];
    assign w_lbv = w_lb_rd[k*DATA_WIDTH +: DATA_WIDTH];
    assign w_hm  = (w_px > w_hd) ? w_px : w_hd;
    assign w_mx  = (w_lbv > w_hm) ? w_lbv : w_hm;

    assign w_hmax[k*DATA_WIDTH +: DATA_WIDTH] = w_hm;
`ifdef RELU_FUSE_EN
    assign w_res[k*DATA_WIDTH +: DATA_WIDTH] = w_mx[DATA_WIDTH-1] ? '0 : w_mx;
`else
    assign w_res[k*DATA_WIDTH +: DATA_WIDTH] = w_mx;
`endif
  end

  // Position counters and output register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      // A load takes priority over a drain so back-to-back results never
      // create a bubble in o_valid.
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_res;
        r_last  <= w_row_last && w_col_last;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Datapath storage is not reset: every entry is written earlier in the
  // frame than it is read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (!w_col_odd) begin
        r_h <= i_data;
      end else if (!w_row_odd) begin
        r_lb[w_lb_idx] <= w_hmax;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_relu_pool_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_pool_stream
// Purpose  : Self-checking bench for relu_pool_stream. A 4x4x2 instance is
//            driven with ramp and constant frames; expected pooled pixels are
//            queued when the closing beat of each window is accepted and
//            compared when the DUT transfers them. A 2x2 instance covers the
//            smallest frame geometry. Honours RELU_FUSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relu_pool_stream;

  localparam int H  = 4;
  localparam int W  = 4;
  localparam int D  = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          i_valid, o_ready, o_valid, i_ready, o_last;
  logic [15:0]   i_data, o_data;
  logic          i_valid2, o_ready2, o_valid2, i_ready2, o_last2;
  logic [15:0]   i_data2, o_data2;

  always #5 clk = ~clk;

  relu_pool_stream #(.H(H), .W(W), .D(D), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last)
  );

  relu_pool_stream #(.H(2), .W(2), .D(D), .DATA_WIDTH(DW)) u_dut2 (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid2), .o_ready(o_ready2), .i_data(i_data2),
    .o_valid(o_valid2), .i_ready(i_ready2), .o_data(o_data2), .o_last(o_last2)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  typedef struct packed {
    int          end_beat;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic        last;
  } ramp_vec_t;

  typedef struct packed {
    logic [7:0]  pix;
    logic [7:0]  expv;
  } const_vec_t;

  ramp_vec_t  ramp_tbl [4];
  const_vec_t const_tbl [3];
  exp_t       sb [$];
  exp_t       mon_e;
  int         checks   = 0;
  int         failures = 0;
  int         n_out    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] relu_f(input logic [7:0] v);
`ifdef RELU_FUSE_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  function automatic bit is_window_end(input int idx);
    foreach (ramp_tbl[j]) if (ramp_tbl[j].end_beat == idx) return 1'b1;
    return 1'b0;
  endfunction

  // Output monitor: sample just before the rising edge, when a transfer is
  // about to happen.
  always begin
    @(negedge clk);
    #4;
    if (resetn && o_valid && i_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %0h expected none", o_data);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", {16'h0, o_data}, {16'h0, mon_e.data});
        check("out_last", {31'h0, o_last}, {31'h0, mon_e.last});
      end
    end
  end

  task automatic send_beat(input logic [15:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = d;
    for (int t = 0; t < 200; t++) begin
      #4;
      if (o_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got o_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic send_beat2(input logic [15:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    i_valid2 = 1'b1;
    i_data2  = d;
    for (int t = 0; t < 200; t++) begin
      #4;
      if (o_ready2) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send2_timeout: got o_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    i_valid  = 1'b0;
    i_valid2 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Ramp beats: ch0 = r*4+c, ch1 = -(r*4+c).
  task automatic send_ramp(input int first, input int count, input bit chk_lat);
    for (int idx = first; idx < first + count; idx++) begin
      logic [7:0] v;
      logic [7:0] nv;
      bit         ok;
      exp_t       e;
      v  = 8'(idx);
      nv = 8'h00 - v;
      send_beat({nv, v}, ok);
      if (ok) begin
        foreach (ramp_tbl[j]) begin
          if (ramp_tbl[j].end_beat == idx) begin
            e.data = {relu_f(ramp_tbl[j].e1), relu_f(ramp_tbl[j].e0)};
            e.last = ramp_tbl[j].last;
            sb.push_back(e);
          end
        end
        if (chk_lat) begin
          #1;
          check("latency_valid", {31'h0, o_valid}, {31'h0, is_window_end(idx)});
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    exp_t e;

    ramp_tbl[0] = '{end_beat: 5,  e0: 8'd5,  e1: 8'h00, last: 1'b0};
    ramp_tbl[1] = '{end_beat: 7,  e0: 8'd7,  e1: 8'hFE, last: 1'b0};
    ramp_tbl[2] = '{end_beat: 13, e0: 8'd13, e1: 8'hF8, last: 1'b0};
    ramp_tbl[3] = '{end_beat: 15, e0: 8'd15, e1: 8'hF6, last: 1'b1};
    const_tbl[0] = '{pix: 8'h80, expv: 8'h80};
    const_tbl[1] = '{pix: 8'h7F, expv: 8'h7F};
    const_tbl[2] = '{pix: 8'hFF, expv: 8'hFF};

    resetn   = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_data   = '0;
    i_valid2 = 1'b0;
    i_ready2 = 1'b0;
    i_data2  = '0;

    // Reset state, with i_ready low so o_ready depends on o_valid alone.
    #12;
    check("rst_o_valid", {31'h0, o_valid}, 32'h0);
    check("rst_o_data",  {16'h0, o_data},  32'h0);
    check("rst_o_last",  {31'h0, o_last},  32'h0);
    check("rst_o_ready", {31'h0, o_ready}, 32'h1);
    check("rst_o_valid2", {31'h0, o_valid2}, 32'h0);
    @(negedge clk);
    resetn   = 1'b1;
    i_ready  = 1'b1;
    i_ready2 = 1'b1;
    @(negedge clk);
    check("post_rst_o_ready", {31'h0, o_ready}, 32'h1);

    // Single ramp frame with per-beat latency check.
    n_out = 0;
    send_ramp(0, 16, 1'b1);
    idle(4);
    check("ramp_count", n_out, 4);
    check("ramp_sb_empty", sb.size(), 0);

    // Constant frames from the table.
    foreach (const_tbl[v]) begin
      n_out = 0;
      for (int idx = 0; idx < 16; idx++) begin
        send_beat({const_tbl[v].pix, const_tbl[v].pix}, ok);
        if (ok && is_window_end(idx)) begin
          e.data = {relu_f(const_tbl[v].expv), relu_f(const_tbl[v].expv)};
          e.last = (idx == 15);
          sb.push_back(e);
        end
      end
      idle(4);
      check("const_count", n_out, 4);
    end

    // Three back-to-back ramp frames.
    n_out = 0;
    for (int f = 0; f < 3; f++) send_ramp(0, 16, 1'b1);
    idle(4);
    check("b2b_count", n_out, 12);
    check("b2b_sb_empty", sb.size(), 0);

    // Backpressure: hold i_ready low from the first output.
    n_out = 0;
    @(negedge clk);
    i_ready = 1'b0;
    fork
      send_ramp(0, 16, 1'b0);
      begin
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          #4;
          if (o_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("bp_valid_seen", {31'h0, seen}, 32'h1);
        check("bp_ready_drop", {31'h0, o_ready}, 32'h0);
        for (int k = 0; k < 10; k++) begin
          check("bp_hold_data", {16'h0, o_data}, {16'h0, relu_f(8'h00), 8'h05});
          check("bp_hold_valid", {31'h0, o_valid}, 32'h1);
          @(negedge clk);
          #4;
        end
        @(negedge clk);
        i_ready = 1'b1;
      end
    join
    idle(4);
    check("bp_count", n_out, 4);
    check("bp_sb_empty", sb.size(), 0);

    // Reset mid-frame while an output is pending.
    n_out = 0;
    send_ramp(0, 6, 1'b1);
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, o_valid}, 32'h0);
    check("mid_rst_ready", {31'h0, o_ready}, 32'h1);
    sb.delete();
    i_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    n_out = 0;
    send_ramp(0, 16, 1'b1);
    idle(4);
    check("after_rst_count", n_out, 4);
    check("after_rst_sb_empty", sb.size(), 0);

    // Smallest geometry: 2x2 frames streamed back-to-back, one output each.
    for (int f = 0; f < 3; f++) begin
      for (int idx = 0; idx < 4; idx++) begin
        logic [7:0] v;
        v = 8'(f * 10 + idx);
        send_beat2({8'h00 - v, v}, ok);
        if (ok) begin
          #1;
          check("g2_valid", {31'h0, o_valid2}, {31'h0, (idx == 3)});
          if (idx == 3) begin
            check("g2_data", {16'h0, o_data2},
                  {16'h0, relu_f(8'h00 - 8'(f * 10)), 8'(f * 10 + 3)});
            check("g2_last", {31'h0, o_last2}, 32'h1);
          end
        end
      end
    end
    idle(2);
    check("g2_drained", {31'h0, o_valid2}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
